dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, sets the number of extra wait cycles per memory access (range 0..15).
REQ-002 Parameter DEPTH_LOG2, default 6, sets the internal word array depth to 2^DEPTH_LOG2 32-bit words.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 dm2reg_M  in  1  MEM-stage load request (read).
REQ-006 we_dm_M  in  1  MEM-stage store request (write).
REQ-007 alu_out_M  in  32  byte address of the access.
REQ-008 wd_dm_M  in  32  store data.
REQ-009 rd_dm  out  32  registered load data.
REQ-010 stall_M  out  1  pipeline hold; while high, IF/ID/EX/MEM registers SHALL NOT advance.
REQ-011 misalign_M  out  1  one-cycle flag for an access with alu_out_M[1:0] != 0.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-013 Request present = dm2reg_M | we_dm_M.
- Both asserted SHALL be treated as a write; no read occurs.
REQ-014 IDLE, request present, aligned address: stall_M=1 combinationally that cycle.
- Latch address index, write data and op at the edge.
- Load the wait counter with WAIT_CYCLES.
- Go to BUSY.
REQ-015 IDLE, request present, alu_out_M[1:0] != 0:
- misalign_M=1 and stall_M=0 in that same cycle.
- No array access; state stays IDLE.
REQ-016 BUSY: stall_M=1.
- Counter != 0: decrement and stay in BUSY.
- Counter == 0: perform the access at that edge and go to DONE.
- Write: array[index] <= latched data.
- Read: rd_dm <= array[index].
REQ-017 DONE: stall_M=0 so the pipeline advances at this edge; next state SHALL be IDLE unconditionally.
- The still-present request SHALL NOT be re-accepted in DONE.
REQ-018 Latency: an aligned access holds stall_M high for exactly WAIT_CYCLES+2 cycles.
- DONE (stall_M=0) follows on the next cycle.
REQ-019 Index = latched alu_out_M[DEPTH_LOG2+1:2].
- Upper address bits SHALL be ignored, so addresses wrap modulo 4*2^DEPTH_LOG2 bytes.
REQ-020 rd_dm SHALL hold its value until the next completed read.
- Writes and misaligned requests SHALL NOT change rd_dm.
REQ-021 Input changes during BUSY or DONE SHALL be ignored; only the values latched in IDLE are used.
REQ-022 With WAIT_CYCLES=0, BUSY SHALL last one cycle and the access SHALL complete at the end of that cycle.
REQ-023 With no request in IDLE: stall_M=0, misalign_M=0, and no state change.

Reset
REQ-024 While rst=1 at a rising edge:
- State <= IDLE, wait counter <= 0, rd_dm <= 0.
- Latched address, data and op <= 0.
REQ-025 stall_M and misalign_M SHALL be 0 during any cycle in which rst=1.
REQ-026 Reset during BUSY SHALL abort the access.
- A pending write SHALL NOT be committed.
- rd_dm SHALL read 0 after reset.
REQ-027 Array contents SHALL NOT be cleared by reset.

Verification
REQ-028 WAIT_CYCLES=2: write 0xDEADBEEF to 0x0000_0010 -> stall_M high 4 cycles then low 1 cycle (DONE); a later read of 0x10 -> rd_dm=0xDEADBEEF in DONE with 4 stall cycles.
REQ-029 Read of 0x0000_0013 -> misalign_M=1 and stall_M=0 in the same cycle; rd_dm unchanged; state IDLE next cycle.
REQ-030 DEPTH_LOG2=6: write 0x1234_5678 to 0x0000_0104, then read 0x0000_0004 -> rd_dm=0x1234_5678 (wrap).
REQ-031 Write 0xAAAA_AAAA to 0x20 with rst pulsed on the 2nd BUSY cycle -> stall_M=0 next cycle; a subsequent read of 0x20 returns the prior contents, not 0xAAAA_AAAA.
REQ-032 dm2reg_M=we_dm_M=1 at 0x30 with wd_dm_M=0x5 -> treated as write; rd_dm unchanged; a read of 0x30 then returns 0x5.
REQ-033 Request held high through DONE and one more cycle, WAIT_CYCLES=0 -> two separate accesses, each with 2 stall cycles, separated by exactly one DONE cycle with stall_M=0.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Data-memory port bundle between the MEM stage and the memory responder.
interface dmem_responder_if;
    logic        dm2reg_M;
    logic        we_dm_M;
    logic [31:0] alu_out_M;
    logic [31:0] wd_dm_M;
    logic [31:0] rd_dm;
    logic        stall_M;
    logic        misalign_M;

    modport slave (
        input  dm2reg_M, we_dm_M, alu_out_M, wd_dm_M,
        output rd_dm, stall_M, misalign_M
    );

    modport master (
        output dm2reg_M, we_dm_M, alu_out_M, wd_dm_M,
        input  rd_dm, stall_M, misalign_M
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: stalls the pipeline for WAIT_CYCLES+2
// cycles per aligned access, flags misaligned accesses without touching memory.
module dmem_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned DEPTH_LOG2  = 6
) (
    input logic              clk,
    input logic              rst,
    dmem_responder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    op_we_q, op_we_d;
    logic [31:0]             rd_q, rd_d;
    logic                    mem_we;
    logic                    stall;
    logic                    misalign;
    logic                    req;
    logic                    aligned;
    logic [31:0]             mem_q [2**DEPTH_LOG2];

    // Upper address bits are deliberately dropped so accesses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.alu_out_M[31:DEPTH_LOG2+2];

    assign req     = bus.dm2reg_M | bus.we_dm_M;
    assign aligned = (bus.alu_out_M[1:0] == 2'b00);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        op_we_d  = op_we_q;
        rd_d     = rd_q;
        mem_we   = 1'b0;
        stall    = 1'b0;
        misalign = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (!aligned) begin
                        misalign = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        idx_d   = bus.alu_out_M[DEPTH_LOG2+1:2];
                        wdata_d = bus.wd_dm_M;
                        op_we_d = bus.we_dm_M;
                        cnt_d   = 4'(WAIT_CYCLES);
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                    if (op_we_q) mem_we = 1'b1;
                    else         rd_d   = mem_q[idx_q];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Reset masks the handshake outputs and aborts any pending write.
        if (rst) begin
            stall    = 1'b0;
            misalign = 1'b0;
            mem_we   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            op_we_q <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            op_we_q <= op_we_d;
            rd_q    <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[idx_q] <= wdata_q;
    end

    assign bus.rd_dm      = rd_q;
    assign bus.stall_M    = stall;
    assign bus.misalign_M = misalign;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (WAIT_CYCLES=2 and 0) checked against
// a cycle-count model plus directed literal expectations.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic [1:0]  rst_i = 2'b11;
    logic [1:0]  rd_i = '0;
    logic [1:0]  we_i = '0;
    logic [31:0] addr_i [2];
    logic [31:0] wd_i [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder_if bus2 ();
    dmem_responder_if bus0 ();

    assign bus2.dm2reg_M = rd_i[0];
    assign bus2.we_dm_M  = we_i[0];
    assign bus2.alu_out_M = addr_i[0];
    assign bus2.wd_dm_M  = wd_i[0];
    assign bus0.dm2reg_M = rd_i[1];
    assign bus0.we_dm_M  = we_i[1];
    assign bus0.alu_out_M = addr_i[1];
    assign bus0.wd_dm_M  = wd_i[1];

    dmem_responder #(.WAIT_CYCLES(2), .DEPTH_LOG2(6)) dut2 (
        .clk(clk), .rst(rst_i[0]), .bus(bus2.slave));
    dmem_responder #(.WAIT_CYCLES(0), .DEPTH_LOG2(6)) dut0 (
        .clk(clk), .rst(rst_i[1]), .bus(bus0.slave));

    function automatic logic get_stall(int d);
        return (d == 0) ? bus2.stall_M : bus0.stall_M;
    endfunction
    function automatic logic get_mis(int d);
        return (d == 0) ? bus2.misalign_M : bus0.misalign_M;
    endfunction
    function automatic logic [31:0] get_rd(int d);
        return (d == 0) ? bus2.rd_dm : bus0.rd_dm;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted access costs W+2 stall cycles, then one free cycle.
    int          m_wait [2] = '{2, 0};
    bit          m_act  [2] = '{0, 0};
    int          m_left [2];
    bit          m_done [2];
    int          m_idx  [2];
    logic [31:0] m_wd   [2];
    bit          m_we   [2];
    logic [31:0] m_mem  [2][64];
    bit          m_memv [2][64];
    logic [31:0] m_rd   [2];
    bit          m_rdv  [2];

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_i[d]) begin
                m_act[d] = 1; m_left[d] = 0; m_done[d] = 0;
                m_rd[d] = 0; m_rdv[d] = 1;
            end else if (!m_act[d]) begin
            end else if (m_done[d]) begin
                m_done[d] = 0;
            end else if (m_left[d] > 0) begin
                m_left[d]--;
                if (m_left[d] == 0) begin
                    m_done[d] = 1;
                    if (m_we[d]) begin
                        m_mem[d][m_idx[d]] = m_wd[d];
                        m_memv[d][m_idx[d]] = 1;
                    end else begin
                        m_rd[d] = m_mem[d][m_idx[d]];
                        m_rdv[d] = m_memv[d][m_idx[d]];
                    end
                end
            end else if ((rd_i[d] || we_i[d]) && addr_i[d] % 4 == 0) begin
                m_idx[d]  = int'((addr_i[d] % 256) / 4);
                m_wd[d]   = wd_i[d];
                m_we[d]   = we_i[d];
                m_left[d] = m_wait[d] + 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (m_act[d]) begin
                logic req, idle, es, em;
                req  = rd_i[d] || we_i[d];
                idle = !m_done[d] && m_left[d] == 0;
                es = !rst_i[d] && (m_left[d] > 0 || (idle && req && addr_i[d] % 4 == 0));
                em = !rst_i[d] && idle && req && addr_i[d] % 4 != 0;
                chk($sformatf("model_stall%0d", d), {31'd0, get_stall(d)}, {31'd0, es});
                chk($sformatf("model_mis%0d", d), {31'd0, get_mis(d)}, {31'd0, em});
                if (m_rdv[d]) chk($sformatf("model_rd%0d", d), get_rd(d), m_rd[d]);
            end
        end
    end

    // Drives one request and holds it until the first stall-free cycle.
    task automatic access(input int d, input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] wd, output int stalls, output bit mis,
                          output logic [31:0] rdv);
        bit fin;
        rd_i[d] = r; we_i[d] = w; addr_i[d] = a; wd_i[d] = wd;
        stalls = 0; mis = 0; fin = 0; rdv = '0;
        for (int i = 0; i < 40 && !fin; i++) begin
            @(negedge clk);
            if (i == 0) mis = get_mis(d);
            if (get_stall(d)) stalls++;
            else begin rdv = get_rd(d); fin = 1; end
        end
        if (!fin) chk("timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        rd_i[d] = 0; we_i[d] = 0; addr_i[d] = '0; wd_i[d] = '0;
    endtask

    initial begin
        int st; bit ms; logic [31:0] rv; logic [5:0] pat;
        addr_i[0] = '0; addr_i[1] = '0; wd_i[0] = '0; wd_i[1] = '0;
        repeat (3) @(posedge clk);
        #1 rst_i = 2'b00;
        @(negedge clk);
        chk("reset_rd", bus2.rd_dm, 32'h0);
        chk("reset_stall", {31'd0, bus2.stall_M}, 32'h0);
        @(posedge clk); #1;

        access(0, 0, 1, 32'h20, 32'h1111_2222, st, ms, rv);
        access(0, 0, 1, 32'h10, 32'hDEAD_BEEF, st, ms, rv);
        chk("write_stalls", st, 4);
        chk("write_rd_unchanged", rv, 32'h0);
        access(0, 1, 0, 32'h10, 32'h0, st, ms, rv);
        chk("read_stalls", st, 4);
        chk("read_rd", rv, 32'hDEAD_BEEF);

        access(0, 1, 0, 32'h13, 32'h0, st, ms, rv);
        chk("misalign_flag", {31'd0, ms}, 32'd1);
        chk("misalign_stalls", st, 0);
        chk("misalign_rd", rv, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("after_mis_stall", {31'd0, bus2.stall_M}, 32'd0);
        chk("after_mis_flag", {31'd0, bus2.misalign_M}, 32'd0);
        @(posedge clk); #1;

        access(0, 0, 1, 32'h104, 32'h1234_5678, st, ms, rv);
        access(0, 1, 0, 32'h4, 32'h0, st, ms, rv);
        chk("wrap_rd", rv, 32'h1234_5678);

        // Reset lands on the second BUSY cycle of a write.
        we_i[0] = 1; addr_i[0] = 32'h20; wd_i[0] = 32'hAAAA_AAAA;
        @(posedge clk); #1;
        @(posedge clk); #1 rst_i[0] = 1;
        @(negedge clk);
        chk("rst_cycle_stall", {31'd0, bus2.stall_M}, 32'd0);
        @(posedge clk); #1;
        rst_i[0] = 0; we_i[0] = 0; addr_i[0] = '0; wd_i[0] = '0;
        @(negedge clk);
        chk("post_rst_stall", {31'd0, bus2.stall_M}, 32'd0);
        chk("post_rst_rd", bus2.rd_dm, 32'h0);
        @(posedge clk); #1;
        access(0, 1, 0, 32'h20, 32'h0, st, ms, rv);
        chk("aborted_write", rv, 32'h1111_2222);

        access(0, 1, 1, 32'h30, 32'h5, st, ms, rv);
        chk("both_is_write_stalls", st, 4);
        chk("both_rd_unchanged", rv, 32'h1111_2222);
        access(0, 1, 0, 32'h30, 32'h0, st, ms, rv);
        chk("both_readback", rv, 32'h5);
        access(0, 1, 0, 32'h10, 32'h0, st, ms, rv);
        chk("mem_survives_rst", rv, 32'hDEAD_BEEF);

        access(1, 0, 1, 32'h8, 32'h77, st, ms, rv);
        chk("w0_write_stalls", st, 2);
        rd_i[1] = 1; addr_i[1] = 32'h8;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pat[5 - i] = bus0.stall_M;
            if (i == 2 || i == 5) chk("w0_rd", bus0.rd_dm, 32'h77);
            @(posedge clk); #1;
        end
        rd_i[1] = 0; addr_i[1] = '0;
        chk("w0_held_pattern", {26'd0, pat}, {26'd0, 6'b110110});

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
